regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Shares the single register-file write port (A3/WD3/WE3) between two writeback
//  sources (ALU, LSU) with valid/ready handshakes and registers the winning write.
//  Keeps a per-register busy scoreboard so decode can stall on RAW hazards.
//  Sits between execute/memory stages and register_file; drives A3, WD3 and WE3.
// PARAMETERS
//  XLEN      32  data width of writeback data and WD3
//  AW        5   register address width (2**AW registers; x0 hardwired zero)
//  MAX_WAIT  3   consecutive ALU losses before the ALU is forced to win (1..15)
// PORTS
//  clk        in   1     rising-edge clock
//  srst       in   1     synchronous reset, active high
//  alu_valid  in   1     ALU writeback request
//  alu_rd     in   AW    ALU destination register
//  alu_data   in   XLEN  ALU result
//  alu_ready  out  1     ALU request accepted this cycle (combinational)
//  lsu_valid  in   1     LSU load-writeback request
//  lsu_rd     in   AW    LSU destination register
//  lsu_data   in   XLEN  LSU load data
//  lsu_ready  out  1     LSU request accepted this cycle (combinational)
//  issue_valid in  1     decode issued an instruction that writes issue_rd
//  issue_rd   in   AW    destination register of the issued instruction
//  rs1, rs2   in   AW    source registers queried by decode
//  rs1_busy   out  1     sb[rs1] pending write (0 when rs1==0)
//  rs2_busy   out  1     sb[rs2] pending write (0 when rs2==0)
//  rf_a3      out  AW    register_file A3
//  rf_wd3     out  XLEN  register_file WD3
//  rf_we3     out  1     register_file WE3
// BEHAVIOUR
//  Reset (srst=1 at posedge): rf_we3=0, rf_a3=0, rf_wd3=0, scoreboard all 0,
//   wait_cnt=0, state=LSU_PRI. alu_ready/lsu_ready are 0 while srst=1.
//   A grant pending in the output register is dropped.
//  Arbiter FSM (2 states):
//   LSU_PRI: both valid -> LSU wins, wait_cnt++; when wait_cnt reaches MAX_WAIT-1
//    on a loss -> go to ALU_PRI. Only one valid -> that one wins.
//   ALU_PRI: ALU wins if alu_valid; on an ALU grant -> wait_cnt=0, go to LSU_PRI.
//    If alu_valid=0, LSU may win; the state stays ALU_PRI.
//   Any ALU grant in LSU_PRI clears wait_cnt. wait_cnt saturates and never wraps.
//  Handshake: xxx_ready=1 only for the granted source, at most one per cycle.
//   Accept = valid & ready. A valid that is not granted must stay asserted with
//   stable rd/data until accepted.
//  Write stage, 1-cycle latency: accept in cycle N -> rf_we3=1 with rf_a3/rf_wd3
//   registered from the winner in cycle N+1. No accept -> rf_we3=0 (a3/wd3 hold).
//   Accept with rd==0 is handshaken normally, but rf_we3 stays 0 (x0 never written).
//  Scoreboard sb[2**AW-1:1], registered:
//   set when issue_valid & issue_rd!=0; clear when rf_we3=1 for rf_a3.
//   Set and clear of the same register in the same cycle -> set wins
//    (newer producer).
//   Busy outputs are combinational reads of sb. A write occurring this cycle is
//    not bypassed; busy drops the cycle after rf_we3.
//   sb[0] does not exist; issue_rd==0 is ignored.
// TESTING
//  1 Reset: assert srst with both valid -> readies=0, rf_we3=0, busy=0 next cycle.
//  2 Single ALU: alu_valid, rd=5, data=0xDEADBEEF in cycle N -> alu_ready=1 in N;
//    rf_we3=1, a3=5, wd3=0xDEADBEEF in N+1; rf_we3=0 in N+2.
//  3 Contention: both valid continuously, MAX_WAIT=3 -> grants LSU,LSU,LSU,ALU,
//    repeating; ALU is never starved.
//  4 x0: lsu_valid with rd=0 -> lsu_ready=1; rf_we3 stays 0; rs1=0 gives busy=0.
//  5 Scoreboard: issue rd=7 -> rs1_busy(rs1=7)=1 next cycle; ALU write rd=7 ->
//    busy clears the cycle after rf_we3. Issue rd=7 in the write cycle -> busy stays 1.
//  6 Mid-op reset: accept in N, srst in N -> rf_we3=0 in N+1, scoreboard clear.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port
// and tracks pending destination registers for decode's RAW-hazard stall.
module regfile_wb_scheduler #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 3
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd3,
    output logic            rf_we3
);

    localparam int NREG = 2 ** AW;
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    typedef enum logic {LSU_PRI, ALU_PRI} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic            alu_gnt, lsu_gnt;
    logic            we_q, we_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [NREG-1:0] sb_q, sb_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (!srst) begin
            case (state_q)
                LSU_PRI: begin
                    if (lsu_valid) begin
                        lsu_gnt = 1'b1;
                        if (alu_valid) begin
                            if (wait_q != 4'hF) wait_d = wait_q + 4'd1;
                            // Third consecutive loss (MAX_WAIT=3) hands priority to the ALU.
                            if (wait_q >= WAIT_LAST) state_d = ALU_PRI;
                        end
                    end else if (alu_valid) begin
                        alu_gnt = 1'b1;
                        wait_d  = 4'd0;
                    end
                end
                ALU_PRI: begin
                    if (alu_valid) begin
                        alu_gnt = 1'b1;
                        wait_d  = 4'd0;
                        state_d = LSU_PRI;
                    end else if (lsu_valid) begin
                        lsu_gnt = 1'b1;
                    end
                end
                default: state_d = LSU_PRI;
            endcase
        end
    end

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    always_comb begin
        we_d = (alu_gnt && (alu_rd != '0)) || (lsu_gnt && (lsu_rd != '0));
        a3_d = a3_q;
        wd_d = wd_q;
        if (we_d) begin
            a3_d = alu_gnt ? alu_rd : lsu_rd;
            wd_d = alu_gnt ? alu_data : lsu_data;
        end
    end

    // Clear for the retiring write first so a same-cycle issue (newer producer) wins.
    always_comb begin
        sb_d = sb_q;
        if (we_q) sb_d[a3_q] = 1'b0;
        if (issue_valid && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= LSU_PRI;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            wd_q    <= '0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            a3_q    <= a3_d;
            wd_q    <= wd_d;
            sb_q    <= sb_d;
        end
    end

    assign rf_we3   = we_q;
    assign rf_a3    = a3_q;
    assign rf_wd3   = wd_q;
    assign rs1_busy = (rs1 != '0) && sb_q[rs1];
    assign rs2_busy = (rs2 != '0) && sb_q[rs2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: per-cycle vector table plus
// hand-written contention and priority sequences.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        srst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.XLEN(32), .AW(5), .MAX_WAIT(3)) dut (
        .clk(clk), .srst(srst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
    );

    typedef struct {
        logic        srst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1, r2;
        logic        e_ar, e_lr, e_b1, e_b2, e_we;
        logic        chk_ad;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic s, logic av, logic [4:0] ard, logic [31:0] ad,
        logic lv, logic [4:0] lrd, logic [31:0] ld,
        logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
        logic e_ar, logic e_lr, logic e_b1, logic e_b2, logic e_we,
        logic chk_ad, logic [4:0] e_a3, logic [31:0] e_wd);
        vec_t v;
        v.srst = s; v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld; v.iv = iv; v.ird = ird;
        v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_we = e_we;
        v.chk_ad = chk_ad; v.e_a3 = e_a3; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        srst = v.srst;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
        issue_valid = v.iv; issue_rd = v.ird;
        rs1 = v.r1; rs2 = v.r2;
    endtask

    task automatic set_both(logic av, logic lv);
        srst = 1'b0; issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        alu_valid = av; alu_rd = 5'd1; alu_data = 32'hA1;
        lsu_valid = lv; lsu_rd = 5'd2; lsu_data = 32'h1B;
    endtask

    initial begin
        logic exp_alu[8];
        logic prev_alu;
        exp_alu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset, single ALU write, x0 write
        tbl.push_back(mk(1,1,5,32'h11,1,6,32'h22,0,0,5,6, 0,0,0,0,0,1,0,0));
        tbl.push_back(mk(0,1,5,32'hDEADBEEF,0,0,0,0,0,5,0, 1,0,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,1,5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,0,1,0,32'h12345678,0,0,0,0, 0,1,0,0,0,1,5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // scoreboard set / clear
        tbl.push_back(mk(0,0,0,0,0,0,0,1,7,7,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,7,32'h77,0,0,0,0,0,7,7, 1,0,1,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,7,0, 0,0,1,0,1,1,7,32'h77));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,7,0, 0,0,0,0,0,1,7,32'h77));
        // issue in the write cycle keeps the register busy
        tbl.push_back(mk(0,0,0,0,0,0,0,1,7,7,0, 0,0,0,0,0,1,7,32'h77));
        tbl.push_back(mk(0,1,7,32'h99,0,0,0,0,0,7,0, 1,0,1,0,0,1,7,32'h77));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,7,7,0, 0,0,1,0,1,1,7,32'h99));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,7,0, 0,0,1,0,0,1,7,32'h99));
        tbl.push_back(mk(0,1,7,32'hAA,0,0,0,0,0,7,0, 1,0,1,0,0,1,7,32'h99));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,7,0, 0,0,1,0,1,1,7,32'hAA));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,7,0, 0,0,0,0,0,1,7,32'hAA));
        // issue_rd==0 ignored
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0,1,7,32'hAA));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,7, 0,0,0,0,0,1,7,32'hAA));
        // mid-operation reset
        tbl.push_back(mk(0,0,0,0,0,0,0,1,10,10,0, 0,0,0,0,0,1,7,32'hAA));
        tbl.push_back(mk(1,1,9,32'h55,0,0,0,1,9,10,9, 0,0,1,0,0,1,7,32'hAA));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,10,9, 0,0,0,0,0,1,0,0));

        srst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].e_lr));
            chk($sformatf("row%0d rs1_busy", i),  32'(rs1_busy),  32'(tbl[i].e_b1));
            chk($sformatf("row%0d rs2_busy", i),  32'(rs2_busy),  32'(tbl[i].e_b2));
            chk($sformatf("row%0d rf_we3", i),    32'(rf_we3),    32'(tbl[i].e_we));
            if (tbl[i].chk_ad) begin
                chk($sformatf("row%0d rf_a3", i),  32'(rf_a3), 32'(tbl[i].e_a3));
                chk($sformatf("row%0d rf_wd3", i), rf_wd3,     tbl[i].e_wd);
            end
        end

        // continuous contention: LSU,LSU,LSU,ALU repeating
        prev_alu = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_both(1'b1, 1'b1);
            #1;
            chk($sformatf("cont%0d alu_ready", i), 32'(alu_ready), 32'(exp_alu[i]));
            chk($sformatf("cont%0d lsu_ready", i), 32'(lsu_ready), 32'(!exp_alu[i]));
            if (i > 0) begin
                chk($sformatf("cont%0d rf_we3", i), 32'(rf_we3), 32'd1);
                chk($sformatf("cont%0d rf_a3", i), 32'(rf_a3), prev_alu ? 32'd1 : 32'd2);
                chk($sformatf("cont%0d rf_wd3", i), rf_wd3, prev_alu ? 32'hA1 : 32'h1B);
            end
            prev_alu = exp_alu[i];
        end

        // ALU_PRI with no ALU request lets the LSU through and keeps ALU priority
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_both(1'b1, 1'b1);
            #1;
            chk($sformatf("pri%0d lsu_ready", i), 32'(lsu_ready), 32'd1);
        end
        @(negedge clk);
        set_both(1'b0, 1'b1);
        #1;
        chk("pri_lsu_only lsu_ready", 32'(lsu_ready), 32'd1);
        chk("pri_lsu_only alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        set_both(1'b1, 1'b1);
        #1;
        chk("pri_both alu_ready", 32'(alu_ready), 32'd1);
        chk("pri_both lsu_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        set_both(1'b0, 1'b0);
        #1;
        chk("pri_write rf_we3", 32'(rf_we3), 32'd1);
        chk("pri_write rf_a3", 32'(rf_a3), 32'd1);
        chk("pri_write rf_wd3", rf_wd3, 32'hA1);
        @(negedge clk);
        #1;
        chk("pri_idle rf_we3", 32'(rf_we3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
